// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address into one req/gnt/rvalid data-bus
// transaction, formats store lanes, extends load data and stalls the core meanwhile.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic              data_err_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic              lsu_valid_o,
  output logic              lsu_busy_o,
  output logic              misaligned_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                misaligned_q, misaligned_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;

  logic                start;
  logic                mis_in;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_ext;
  logic [3:0]          be_fmt;
  logic [DATA_W-1:0]   wdata_fmt;
  logic                in_req;

  // size_q keeps funct3[1:0]: 00 byte, 01 half, 1x word (so 011/110/111 act as word)
  always_comb begin
    start  = (state_q == S_IDLE) && (mem_read_i || mem_write_i);
    mis_in = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
             (funct3_i[1] && (alu_result_i[1:0] != 2'b00));
  end

  always_comb begin
    shifted = data_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                     : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = unsigned_q ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                     : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        be_fmt    = 4'b0001 << addr_q[1:0];
        wdata_fmt = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_fmt    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{wdata_q[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata_q;
      end
    endcase
    if (!we_q) begin
      be_fmt = 4'b1111;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    misaligned_d = misaligned_q;
    err_d        = err_q;
    load_data_d  = load_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d       = alu_result_i;
          size_d       = funct3_i[1:0];
          unsigned_d   = funct3_i[2];
          we_d         = mem_write_i;
          wdata_d      = store_data_i;
          misaligned_d = mis_in;
          err_d        = 1'b0;
          state_d      = mis_in ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (data_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      // rvalid only counts from WAIT onward; a response alongside gnt is dropped
      S_WAIT: begin
        if (data_rvalid_i) begin
          err_d = data_err_i;
          if (!we_q) begin
            load_data_d = data_err_i ? '0 : load_ext;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      misaligned_q <= 1'b0;
      err_q        <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      misaligned_q <= misaligned_d;
      err_q        <= err_d;
      load_data_q  <= load_data_d;
    end
  end

  // Bus fields are only driven during the request phase so idle outputs stay at zero
  always_comb begin
    in_req       = (state_q == S_REQ);
    data_req_o   = in_req;
    data_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    data_we_o    = in_req && we_q;
    data_be_o    = in_req ? be_fmt : 4'b0000;
    data_wdata_o = in_req ? wdata_fmt : '0;
    load_data_o  = load_data_q;
    lsu_valid_o  = (state_q == S_DONE);
    misaligned_o = (state_q == S_DONE) && misaligned_q;
    err_o        = (state_q == S_DONE) && err_q;
    lsu_busy_o   = start || in_req || (state_q == S_WAIT);
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboarded bench for lsu: a driver acts as core and bus, a monitor checks completions
// against a behavioural model of the access rules.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_err;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic [31:0] load_data;
  logic        lsu_valid;
  logic        lsu_busy;
  logic        misaligned;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [31:0] lastLoad = 32'h0;

  typedef struct {
    logic        mis;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t expQ[$];

  lsu dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alu_result_i  (alu_result),
    .store_data_i  (store_data),
    .mem_read_i    (mem_read),
    .mem_write_i   (mem_write),
    .funct3_i      (funct3),
    .data_req_o    (data_req),
    .data_gnt_i    (data_gnt),
    .data_rvalid_i (data_rvalid),
    .data_err_i    (data_err),
    .data_addr_o   (data_addr),
    .data_we_o     (data_we),
    .data_be_o     (data_be),
    .data_wdata_o  (data_wdata),
    .data_rdata_i  (data_rdata),
    .load_data_o   (load_data),
    .lsu_valid_o   (lsu_valid),
    .lsu_busy_o    (lsu_busy),
    .misaligned_o  (misaligned),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int sizeOf(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0] v;
    int sz;
    sz = sizeOf(f3);
    v  = rdata >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] beModel(input int sz, input logic [31:0] addr, input logic st);
    if (!st || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << (addr % 4));
    return ((addr % 4) == 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] wdataModel(input int sz, input logic [31:0] rs2);
    if (sz == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  // Called right after a negedge with the DUT idle; returns right after a negedge, idle again.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [31:0] rdata, input logic errIn,
                               input int gntDly, input int rvDly, input logic spur);
    int   sz;
    logic st;
    logic mis;
    exp_t e;
    sz  = sizeOf(f3);
    st  = wr;
    mis = (sz == 2 && (addr % 2) != 0) || (sz == 4 && (addr % 4) != 0);
    e.mis = mis;
    e.err = mis ? 1'b0 : errIn;
    if (!mis && !st) lastLoad = errIn ? 32'h0 : loadModel(f3, addr, rdata);
    e.data = lastLoad;
    expQ.push_back(e);

    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_result = addr;
    store_data = rs2;
    #1;
    checkOutput("busy_start", {31'b0, lsu_busy}, 32'd1);
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'($urandom);
    alu_result = $urandom;
    store_data = $urandom;
    if (mis) begin
      checkOutput("mis_no_req", {31'b0, data_req}, 32'd0);
      checkOutput("mis_valid", {31'b0, lsu_valid}, 32'd1);
      checkOutput("mis_busy", {31'b0, lsu_busy}, 32'd0);
    end else begin
      for (int c = 0; c <= gntDly; c++) begin
        if (c > 0) @(negedge clk);
        checkOutput("req", {31'b0, data_req}, 32'd1);
        checkOutput("req_busy", {31'b0, lsu_busy}, 32'd1);
        checkOutput("addr", data_addr, addr & 32'hFFFF_FFFC);
        checkOutput("we", {31'b0, data_we}, {31'b0, st});
        checkOutput("be", {28'b0, data_be}, {28'b0, beModel(sz, addr, st)});
        if (st) checkOutput("wdata", data_wdata, wdataModel(sz, rs2));
        data_gnt    = (c == gntDly);
        data_rvalid = spur && (c == gntDly);
        data_err    = data_rvalid;
        data_rdata  = $urandom;
      end
      for (int c = 0; c <= rvDly; c++) begin
        @(negedge clk);
        data_gnt = 1'b0;
        checkOutput("wait_req", {31'b0, data_req}, 32'd0);
        checkOutput("wait_busy", {31'b0, lsu_busy}, 32'd1);
        checkOutput("wait_valid", {31'b0, lsu_valid}, 32'd0);
        data_rvalid = (c == rvDly);
        data_err    = (c == rvDly) ? errIn : 1'b0;
        data_rdata  = (c == rvDly) ? rdata : $urandom;
      end
      @(negedge clk);
      data_rvalid = 1'b0;
      data_err    = 1'b0;
      checkOutput("done_valid", {31'b0, lsu_valid}, 32'd1);
      checkOutput("done_busy", {31'b0, lsu_busy}, 32'd0);
    end
    @(negedge clk);
    checkOutput("valid_pulse", {31'b0, lsu_valid}, 32'd0);
  endtask

  // Monitor: every completion pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && lsu_valid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid actual=1 required=0");
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sb_misaligned", {31'b0, misaligned}, {31'b0, e.mis});
        checkOutput("sb_err", {31'b0, err}, {31'b0, e.err});
        checkOutput("sb_load_data", load_data, e.data);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    alu_result  = '0;
    store_data  = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'd0;
    data_gnt    = 1'b0;
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    data_rdata  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {31'b0, lsu_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, lsu_busy}, 32'd0);
    checkOutput("rst_req", {31'b0, data_req}, 32'd0);
    checkOutput("rst_load", load_data, 32'd0);
    checkOutput("rst_addr", data_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed accesses");
    applyStimulus(1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0, 1, 1, 0);
    applyStimulus(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h80FF_0000, 0, 0, 2, 0);
    applyStimulus(0, 1, 3'b000, 32'h0000_3002, 32'h1234_56AB, 32'h5555_5555, 0, 4, 0, 0);
    applyStimulus(1, 0, 3'b010, 32'h0000_4002, 32'h0, 32'h1111_1111, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 1);
    applyStimulus(1, 1, 3'b001, 32'h0000_6002, 32'hAAAA_8765, 32'h0, 0, 0, 0, 0);

    $display("[TB] random accesses");
    for (int i = 0; i < 150; i++) begin
      int rw;
      rw = $urandom_range(0, 2);
      applyStimulus(rw != 1, rw != 0, 3'($urandom), $urandom, $urandom, $urandom,
                    ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] reset during WAIT");
    applyStimulus(1, 0, 3'b010, 32'h0000_7000, 32'h0, 32'h7654_3210, 0, 0, 0, 0);
    mem_read   = 1'b1;
    funct3     = 3'b010;
    alu_result = 32'h0000_8000;
    @(negedge clk);
    mem_read = 1'b0;
    data_gnt = 1'b1;
    @(negedge clk);
    data_gnt = 1'b0;
    rst_n    = 1'b0;
    lastLoad = 32'h0;
    #1;
    checkOutput("midrst_valid", {31'b0, lsu_valid}, 32'd0);
    checkOutput("midrst_busy", {31'b0, lsu_busy}, 32'd0);
    checkOutput("midrst_load", load_data, lastLoad);
    @(negedge clk);
    rst_n       = 1'b1;
    data_rvalid = 1'b1;
    data_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    data_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("post_valid", {31'b0, lsu_valid}, 32'd0);
      checkOutput("post_busy", {31'b0, lsu_busy}, 32'd0);
      checkOutput("post_req", {31'b0, data_req}, 32'd0);
      checkOutput("post_load", load_data, lastLoad);
      @(negedge clk);
    end

    applyStimulus(1, 0, 3'b000, 32'h0000_9001, 32'h0, 32'h0000_7F00, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the execute path.
- Takes the ALU result as the effective address and runs one data-bus transaction per load/store: req/gnt request phase, then rvalid response phase.
- Generates byte enables and replicated store data. Returns sign- or zero-extended load data.
- Holds the core stalled via lsu_busy_o until the access completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset; asynchronous, active-low
- alu_result_i  in  32  effective address from the ALU
- store_data_i  in  32  rs2 value for stores
- mem_read_i  in  1  control unit: load
- mem_write_i  in  1  control unit: store
- funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus error, sampled with rvalid
- data_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- data_we_o  out  1  1 = write
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  write data
- data_rdata_i  in  32  read data
- load_data_o  out  32  extended load result, registered
- lsu_valid_o  out  1  one-cycle completion pulse
- lsu_busy_o  out  1  stall request to the core
- misaligned_o  out  1  completion was a misaligned access
- err_o  out  1  completion was a bus error

Behaviour:
- Reset: state=IDLE; all outputs 0, including load_data_o.
- Reset asserted mid-transaction: return to IDLE immediately. Any later rvalid/gnt is ignored while IDLE.
- Start condition: state IDLE and (mem_read_i | mem_write_i).
  - Both read and write asserted: treated as a store.
  - funct3 011/110/111: treated as word.
- Misalignment:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
  - Misaligned access issues no bus request.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On start, latch addr, funct3, we and store data.
  - Misaligned: go to DONE with misaligned flag set.
  - Otherwise: go to REQ.
- REQ:
  - data_req_o=1; addr/we/be/wdata come from the latched values and are stable.
  - On data_gnt_i go to WAIT, else stay.
  - req is never dropped before gnt.
- WAIT:
  - On data_rvalid_i capture error, then go to DONE.
  - Loads capture extended data at the same edge.
  - On error, load_data_o is forced to 0.
  - rvalid arriving in the same cycle as gnt (while in REQ) is not a legal bus response and is ignored.
- DONE:
  - lsu_valid_o=1 for exactly one cycle.
  - misaligned_o and err_o are valid only in this cycle.
  - Always return to IDLE.
- lsu_busy_o = (IDLE & start) | REQ | WAIT. It is 0 in DONE, so the core advances on the DONE edge. The next instruction is sampled in the following IDLE cycle.
- Latency: minimum 3 stall cycles (IDLE→REQ→WAIT→DONE) with gnt in REQ and rvalid in the first WAIT cycle. Misaligned access: 1 stall cycle.
- Store formatting:
  - Byte: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - Half: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - Word: be=4'b1111, wdata=rs2.
  - data_we_o=1.
- Load formatting:
  - Loads drive be=4'b1111 and we=0.
  - Result = rdata>>(8*addr[1:0]), then:
    - B: sign-extend bit 7.
    - BU: zero-extend from 8 bits.
    - H: sign-extend bit 15.
    - HU: zero-extend from 16 bits.
    - W: unchanged.
- Stores complete only on rvalid; no data is captured and load_data_o keeps its previous value.

Test Plan:
- LW at 0x0000_1004, gnt in the first REQ cycle, rvalid one cycle later with rdata=0xDEADBEEF → data_addr_o=0x1004, be=1111, we=0; lsu_valid_o high 3 cycles after start; load_data_o=0xDEADBEEF; busy high exactly 3 cycles.
- LB at 0x...03, rdata=0x80FF_0000 → 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at 0x...02 → 0x0000_80FF.
- SB at addr 0x...02, rs2=0x1234_56AB → be=0100, wdata=0xABAB_ABAB, we=1. gnt held low 4 cycles → req and all bus fields stable until gnt.
- LW at 0x...02 → no data_req_o; misaligned_o=1 and lsu_valid_o=1 in the cycle after start; busy for 1 cycle.
- LW with rvalid and data_err_i=1 → err_o=1, load_data_o=0, valid pulses once.
- Reset asserted in WAIT, then rvalid arrives after release → state IDLE, no valid pulse, all outputs 0.
